// File: rtl/pfcop_if.sv
// Operand load, operation start, readout and ready signals of the prime-field coprocessor.
interface pfcop_if;
  localparam int unsigned WORD_W = 16;

  logic              load_en;
  logic [3:0]        load_addr;
  logic [WORD_W-1:0] datain;
  logic              madd_en;
  logic              msub_en;
  logic              mmul_en;
  logic              minv_mdiv;
  logic              minv_mdiv_en;
  logic              out_en;
  logic [1:0]        out_addr;
  logic [WORD_W-1:0] dataout;
  logic              madd_msub_rdy;
  logic              mmul_rdy;
  logic              minv_mdiv_rdy;

  // Host side: drives operands and strobes, observes results.
  modport master (
    output load_en, load_addr, datain,
    output madd_en, msub_en, mmul_en, minv_mdiv, minv_mdiv_en,
    output out_en, out_addr,
    input  dataout, madd_msub_rdy, mmul_rdy, minv_mdiv_rdy
  );

  // Coprocessor side.
  modport slave (
    input  load_en, load_addr, datain,
    input  madd_en, msub_en, mmul_en, minv_mdiv, minv_mdiv_en,
    input  out_en, out_addr,
    output dataout, madd_msub_rdy, mmul_rdy, minv_mdiv_rdy
  );
endinterface

// File: rtl/pfcop.sv
// Prime-field coprocessor: 256-bit modular add/sub, multiply and inverse/divide
// with word-serial operand load and result readout.
module pfcop (
  input  logic   clk,
  input  logic   rst,
  pfcop_if.slave bus
);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned OP_W   = 256;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 9;

  localparam logic [3:0]       ADDR_A   = 4'd3;
  localparam logic [3:0]       ADDR_B   = 4'd4;
  localparam logic [3:0]       ADDR_P   = 4'd5;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(255);
  localparam logic [OP_W-1:0]  ONE      = OP_W'(1);

  typedef enum logic {AS_IDLE,  AS_CALC} as_state_e;
  typedef enum logic {MUL_IDLE, MUL_RUN} mul_state_e;
  typedef enum logic {INV_IDLE, INV_RUN} inv_state_e;

  // x/2 mod p for odd p: add p first when x is odd so the halving is exact.
  function automatic logic [OP_W-1:0] half_mod(input logic [OP_W-1:0] x,
                                               input logic [OP_W-1:0] p);
    logic [OP_W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
    return OP_W'(s >> 1);
  endfunction

  // (x - y) mod p for x, y < p.
  function automatic logic [OP_W-1:0] sub_mod(input logic [OP_W-1:0] x,
                                              input logic [OP_W-1:0] y,
                                              input logic [OP_W-1:0] p);
    logic [OP_W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[OP_W]) d = d + {1'b0, p};
    return d[OP_W-1:0];
  endfunction

  // ---------------- operand registers ----------------
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d, p_q, p_d;
  logic [IDX_W-1:0] ld_cnt_q, ld_cnt_d, ld_idx;
  logic [3:0]       ld_addr_q, ld_addr_d;

  // Word-serial load; a change of target register restarts at word 0.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    ld_cnt_d  = '0;
    ld_addr_d = bus.load_addr;
    ld_idx    = (bus.load_addr == ld_addr_q) ? ld_cnt_q : '0;
    if (bus.load_en) begin
      ld_cnt_d = ld_idx + IDX_W'(1);
      case (bus.load_addr)
        ADDR_A:  a_d[{ld_idx, 4'h0} +: WORD_W] = bus.datain;
        ADDR_B:  b_d[{ld_idx, 4'h0} +: WORD_W] = bus.datain;
        ADDR_P:  p_d[{ld_idx, 4'h0} +: WORD_W] = bus.datain;
        default: ;
      endcase
    end
  end

  // Operand register and load counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      ld_cnt_q  <= '0;
      ld_addr_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      ld_cnt_q  <= ld_cnt_d;
      ld_addr_q <= ld_addr_d;
    end
  end

  // ---------------- modular add / subtract ----------------
  as_state_e       as_state_q, as_state_d;
  logic            as_sub_q, as_sub_d;
  logic            as_rdy_q, as_rdy_d;
  logic [OP_W-1:0] as_a_q, as_a_d, as_b_q, as_b_d, as_p_q, as_p_d;
  logic [OP_W-1:0] r0_q, r0_d;
  logic [OP_W:0]   as_sum, as_diff;
  logic [OP_W-1:0] as_add_res, as_sub_res;

  // Add/sub datapath on the captured operands.
  always_comb begin
    as_sum     = {1'b0, as_a_q} + {1'b0, as_b_q};
    as_add_res = (as_sum >= {1'b0, as_p_q}) ? OP_W'(as_sum - {1'b0, as_p_q})
                                            : as_sum[OP_W-1:0];
    as_diff    = {1'b0, as_a_q} - {1'b0, as_b_q};
    as_sub_res = as_diff[OP_W] ? OP_W'(as_diff + {1'b0, as_p_q})
                               : as_diff[OP_W-1:0];
  end

  // Add/sub control: capture on start, write R0 one cycle later.
  always_comb begin
    as_state_d = as_state_q;
    as_sub_d   = as_sub_q;
    as_rdy_d   = as_rdy_q;
    as_a_d     = as_a_q;
    as_b_d     = as_b_q;
    as_p_d     = as_p_q;
    r0_d       = r0_q;
    case (as_state_q)
      AS_IDLE: begin
        if (bus.madd_en || bus.msub_en) begin
          as_state_d = AS_CALC;
          as_sub_d   = !bus.madd_en;
          as_rdy_d   = 1'b0;
          as_a_d     = a_q;
          as_b_d     = b_q;
          as_p_d     = p_q;
        end
      end
      AS_CALC: begin
        r0_d       = as_sub_q ? as_sub_res : as_add_res;
        as_rdy_d   = 1'b1;
        as_state_d = AS_IDLE;
      end
      default: as_state_d = AS_IDLE;
    endcase
  end

  // Add/sub state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      as_state_q <= AS_IDLE;
      as_sub_q   <= 1'b0;
      as_rdy_q   <= 1'b0;
      as_a_q     <= '0;
      as_b_q     <= '0;
      as_p_q     <= '0;
      r0_q       <= '0;
    end else begin
      as_state_q <= as_state_d;
      as_sub_q   <= as_sub_d;
      as_rdy_q   <= as_rdy_d;
      as_a_q     <= as_a_d;
      as_b_q     <= as_b_d;
      as_p_q     <= as_p_d;
      r0_q       <= r0_d;
    end
  end

  // ---------------- modular multiply ----------------
  mul_state_e       mul_state_q, mul_state_d;
  logic             mul_rdy_q, mul_rdy_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [OP_W-1:0]  m_a_q, m_a_d, m_b_q, m_b_d, m_p_q, m_p_d;
  logic [OP_W-1:0]  r1_q, r1_d;
  logic [OP_W:0]    m_dbl, m_add;
  logic [OP_W-1:0]  m_dbl_red, m_add_red, m_next;

  // One interleaved iteration: R = 2R mod P, then + B mod P if the A bit is set.
  always_comb begin
    m_dbl     = {r1_q, 1'b0};
    m_dbl_red = (m_dbl >= {1'b0, m_p_q}) ? OP_W'(m_dbl - {1'b0, m_p_q})
                                         : m_dbl[OP_W-1:0];
    m_add     = {1'b0, m_dbl_red} + {1'b0, m_b_q};
    m_add_red = (m_add >= {1'b0, m_p_q}) ? OP_W'(m_add - {1'b0, m_p_q})
                                         : m_add[OP_W-1:0];
    m_next    = m_a_q[OP_W-1] ? m_add_red : m_dbl_red;
  end

  // Multiply control: 256 iterations, A consumed MSB-first by shifting.
  always_comb begin
    mul_state_d = mul_state_q;
    mul_rdy_d   = mul_rdy_q;
    mul_cnt_d   = mul_cnt_q;
    m_a_d       = m_a_q;
    m_b_d       = m_b_q;
    m_p_d       = m_p_q;
    r1_d        = r1_q;
    case (mul_state_q)
      MUL_IDLE: begin
        if (bus.mmul_en) begin
          mul_state_d = MUL_RUN;
          mul_rdy_d   = 1'b0;
          mul_cnt_d   = '0;
          m_a_d       = a_q;
          m_b_d       = b_q;
          m_p_d       = p_q;
          r1_d        = '0;
        end
      end
      MUL_RUN: begin
        r1_d      = m_next;
        m_a_d     = {m_a_q[OP_W-2:0], 1'b0};
        mul_cnt_d = mul_cnt_q + CNT_W'(1);
        if (mul_cnt_q == MUL_LAST) begin
          mul_rdy_d   = 1'b1;
          mul_state_d = MUL_IDLE;
        end
      end
      default: mul_state_d = MUL_IDLE;
    endcase
  end

  // Multiply state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_state_q <= MUL_IDLE;
      mul_rdy_q   <= 1'b0;
      mul_cnt_q   <= '0;
      m_a_q       <= '0;
      m_b_q       <= '0;
      m_p_q       <= '0;
      r1_q        <= '0;
    end else begin
      mul_state_q <= mul_state_d;
      mul_rdy_q   <= mul_rdy_d;
      mul_cnt_q   <= mul_cnt_d;
      m_a_q       <= m_a_d;
      m_b_q       <= m_b_d;
      m_p_q       <= m_p_d;
      r1_q        <= r1_d;
    end
  end

  // ---------------- modular inverse / divide ----------------
  inv_state_e      inv_state_q, inv_state_d;
  logic            inv_rdy_q, inv_rdy_d;
  logic [OP_W-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, i_p_q, i_p_d;
  logic [OP_W-1:0] r2_q, r2_d;
  logic [OP_W-1:0] den, num;

  // Binary extended Euclid, one reduction step per cycle.
  always_comb begin
    inv_state_d = inv_state_q;
    inv_rdy_d   = inv_rdy_q;
    u_d         = u_q;
    v_d         = v_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    i_p_d       = i_p_q;
    r2_d        = r2_q;
    den         = bus.minv_mdiv ? b_q : a_q;
    num         = bus.minv_mdiv ? a_q : ONE;
    case (inv_state_q)
      INV_IDLE: begin
        if (bus.minv_mdiv_en) begin
          inv_rdy_d = 1'b0;
          if (den == '0) begin
            r2_d      = '0;
            inv_rdy_d = 1'b1;
          end else begin
            inv_state_d = INV_RUN;
            u_d         = den;
            v_d         = p_q;
            x1_d        = num;
            x2_d        = '0;
            i_p_d       = p_q;
          end
        end
      end
      INV_RUN: begin
        if (u_q == ONE || v_q == ONE || u_q == '0 || v_q == '0) begin
          // A zero u or v only arises for non-coprime operands; finish with 0.
          r2_d        = (u_q == ONE) ? x1_q : ((v_q == ONE) ? x2_q : '0);
          inv_rdy_d   = 1'b1;
          inv_state_d = INV_IDLE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half_mod(x1_q, i_p_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half_mod(x2_q, i_p_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q, i_p_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q, i_p_q);
        end
      end
      default: inv_state_d = INV_IDLE;
    endcase
  end

  // Inverse/divide state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inv_state_q <= INV_IDLE;
      inv_rdy_q   <= 1'b0;
      u_q         <= '0;
      v_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      i_p_q       <= '0;
      r2_q        <= '0;
    end else begin
      inv_state_q <= inv_state_d;
      inv_rdy_q   <= inv_rdy_d;
      u_q         <= u_d;
      v_q         <= v_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      i_p_q       <= i_p_d;
      r2_q        <= r2_d;
    end
  end

  // ---------------- result readout ----------------
  logic [IDX_W-1:0]  out_cnt_q, out_cnt_d;
  logic [WORD_W-1:0] rd_word_c;

  // Readout word counter, held at 0 while out_en is low.
  always_comb begin
    out_cnt_d = bus.out_en ? (out_cnt_q + IDX_W'(1)) : '0;
  end

  // Combinational result word mux.
  always_comb begin
    rd_word_c = '0;
    if (rst && bus.out_en) begin
      case (bus.out_addr)
        2'd0:    rd_word_c = r0_q[{out_cnt_q, 4'h0} +: WORD_W];
        2'd1:    rd_word_c = r1_q[{out_cnt_q, 4'h0} +: WORD_W];
        2'd2:    rd_word_c = r2_q[{out_cnt_q, 4'h0} +: WORD_W];
        default: rd_word_c = '0;
      endcase
    end
  end

  // Readout counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_cnt_q <= '0;
    else      out_cnt_q <= out_cnt_d;
  end

  assign bus.dataout       = rd_word_c;
  assign bus.madd_msub_rdy = as_rdy_q;
  assign bus.mmul_rdy      = mul_rdy_q;
  assign bus.minv_mdiv_rdy = inv_rdy_q;
endmodule

// File: tb/tb_pfcop.sv
// Scoreboard bench for pfcop: readout words are queued as expected values and
// checked by an independent monitor whenever out_en is high.
module tb_pfcop;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pfcop_if bus();

  pfcop dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [255:0] P23 = 256'd23;

  localparam logic [255:0] P192 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] A192 = 256'h5F990446_1A2B3C4D_5E6F7081_92A3B4C5_D6E7F809_334C74C7;
  localparam logic [255:0] B192 = 256'h59BDCEE3_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_2139F0A0;

  localparam logic [255:0] P256 =
    256'hF00D_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D3;
  localparam logic [255:0] A256 =
    256'h1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0_FFFF_0000_AAAA_5555_C0DE_BEEF_0001_8000;
  localparam logic [255:0] B256 =
    256'hE000_EF01_2345_6789_FEDC_BA98_7654_3210_0000_FFFF_5A5A_A5A5_DEAD_F00D_7FFF_FFFF;

  // Reference models using plain wide arithmetic.
  function automatic logic [255:0] model_add(input logic [255:0] a, input logic [255:0] b,
                                             input logic [255:0] p);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, p};
    return s[255:0];
  endfunction

  function automatic logic [255:0] model_mul(input logic [255:0] a, input logic [255:0] b,
                                             input logic [255:0] p);
    logic [511:0] prod;
    prod = ({256'd0, a} * {256'd0, b}) % {256'd0, p};
    return prod[255:0];
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every readout cycle pops one expected word.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.out_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL readout_unexpected: got %h want no readout", bus.dataout);
      end else begin
        e = exp_q.pop_front();
        if (bus.dataout !== e.val) begin
          errors++;
          $display("FAIL %s: got %h want %h", e.name, bus.dataout, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_rdy(input int which);
    case (which)
      0:       return bus.madd_msub_rdy;
      1:       return bus.mmul_rdy;
      default: return bus.minv_mdiv_rdy;
    endcase
  endfunction

  // Continuous 48-cycle load: A, then B, then P without gaps.
  task automatic load_all(input logic [255:0] a, input logic [255:0] b, input logic [255:0] p);
    logic [255:0] v;
    for (int r = 0; r < 3; r++) begin
      v = (r == 0) ? a : ((r == 1) ? b : p);
      for (int i = 0; i < 16; i++) begin
        bus.load_en   = 1'b1;
        bus.load_addr = 4'(3 + r);
        bus.datain    = v[16*i +: 16];
        tick();
      end
    end
    bus.load_en   = 1'b0;
    bus.load_addr = 4'd0;
    bus.datain    = 16'd0;
  endtask

  // which: 0 add, 1 sub, 2 add+sub together, 3 mul, 4 inverse, 5 divide
  task automatic start_op(input int which);
    bus.madd_en      = (which == 0 || which == 2);
    bus.msub_en      = (which == 1 || which == 2);
    bus.mmul_en      = (which == 3);
    bus.minv_mdiv_en = (which == 4 || which == 5);
    bus.minv_mdiv    = (which == 5);
    tick();
    bus.madd_en      = 1'b0;
    bus.msub_en      = 1'b0;
    bus.mmul_en      = 1'b0;
    bus.minv_mdiv_en = 1'b0;
    bus.minv_mdiv    = 1'b0;
  endtask

  task automatic wait_rdy(input int which, input int limit, input string name, output int n);
    n = 0;
    while (!get_rdy(which) && n < limit) begin
      tick();
      n++;
    end
    check(name, 256'(get_rdy(which)), 256'd1);
  endtask

  task automatic read_result(input logic [1:0] sel, input logic [255:0] val, input string name);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.name = $sformatf("%s_w%0d", name, i);
      e.val  = val[16*i +: 16];
      exp_q.push_back(e);
    end
    bus.out_addr = sel;
    bus.out_en   = 1'b1;
    repeat (16) tick();
    bus.out_en   = 1'b0;
    @(negedge clk);
    check({name, "_idle"}, 256'(bus.dataout), 256'd0);
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.load_en      = 1'b0;
    bus.load_addr    = 4'd0;
    bus.datain       = 16'd0;
    bus.madd_en      = 1'b0;
    bus.msub_en      = 1'b0;
    bus.mmul_en      = 1'b0;
    bus.minv_mdiv    = 1'b0;
    bus.minv_mdiv_en = 1'b0;
    bus.out_en       = 1'b0;
    bus.out_addr     = 2'd0;
    #2 rst = 1'b0;
    repeat (3) tick();
    check("reset_add_rdy", 256'(bus.madd_msub_rdy), 256'd0);
    check("reset_mul_rdy", 256'(bus.mmul_rdy), 256'd0);
    check("reset_inv_rdy", 256'(bus.minv_mdiv_rdy), 256'd0);
    check("reset_dataout", 256'(bus.dataout), 256'd0);
    rst = 1'b1;
    tick();

    // Small prime operands, plus a stream to an unused address that must write nothing.
    load_all(256'd5, 256'd20, P23);
    for (int i = 0; i < 16; i++) begin
      bus.load_en   = 1'b1;
      bus.load_addr = 4'd6;
      bus.datain    = 16'hFFFF;
      tick();
    end
    bus.load_en = 1'b0;

    start_op(0);
    check("add_rdy_low_at_start", 256'(bus.madd_msub_rdy), 256'd0);
    wait_rdy(0, 4, "add_rdy", n);
    check("add_latency", 256'(n), 256'd1);
    read_result(2'd0, 256'd2, "add_23");

    start_op(1);
    wait_rdy(0, 4, "sub_rdy", n);
    read_result(2'd0, 256'd8, "sub_23");

    start_op(2);
    wait_rdy(0, 4, "addsub_rdy", n);
    read_result(2'd0, 256'd2, "add_wins_23");

    start_op(3);
    check("mul_rdy_low_at_start", 256'(bus.mmul_rdy), 256'd0);
    wait_rdy(1, 300, "mul_rdy", n);
    check("mul_latency_ok", 256'(n <= 257), 256'd1);
    read_result(2'd1, 256'd8, "mul_23");

    start_op(4);
    check("inv_rdy_low_at_start", 256'(bus.minv_mdiv_rdy), 256'd0);
    wait_rdy(2, 1100, "inv_rdy", n);
    read_result(2'd2, 256'd14, "inv_23");

    start_op(5);
    wait_rdy(2, 1100, "div_rdy", n);
    read_result(2'd2, 256'd6, "div_23");
    read_result(2'd3, 256'd0, "addr3_zero");

    // Zero and unit denominators.
    load_all(256'd0, 256'd20, P23);
    start_op(4);
    wait_rdy(2, 2, "inv_zero_rdy", n);
    read_result(2'd2, 256'd0, "inv_zero");
    load_all(256'd1, 256'd20, P23);
    start_op(4);
    wait_rdy(2, 1100, "inv_one_rdy", n);
    read_result(2'd2, 256'd1, "inv_one");

    // Operands captured at start; a second start while busy is ignored.
    load_all(256'd5, 256'd20, P23);
    start_op(3);
    load_all(256'd7, 256'd20, P23);
    start_op(3);
    wait_rdy(1, 300, "mul_busy_rdy", n);
    check("mul_busy_latency_ok", 256'((49 + n) <= 257), 256'd1);
    read_result(2'd1, 256'd8, "mul_busy");

    // 192-bit prime multiply.
    load_all(A192, B192, P192);
    start_op(3);
    wait_rdy(1, 300, "mul192_rdy", n);
    read_result(2'd1, model_mul(A192, B192, P192), "mul192");

    // Full-width streamed operands, add and multiply running concurrently.
    load_all(A256, B256, P256);
    bus.madd_en = 1'b1;
    bus.mmul_en = 1'b1;
    tick();
    bus.madd_en = 1'b0;
    bus.mmul_en = 1'b0;
    wait_rdy(0, 4, "add256_rdy", n);
    wait_rdy(1, 300, "mul256_rdy", n);
    read_result(2'd0, model_add(A256, B256, P256), "add256");
    read_result(2'd1, model_mul(A256, B256, P256), "mul256");

    // Reset in the middle of a multiply.
    load_all(256'd5, 256'd20, P23);
    start_op(3);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    check("rst_mid_mul_rdy", 256'(bus.mmul_rdy), 256'd0);
    check("rst_mid_add_rdy", 256'(bus.madd_msub_rdy), 256'd0);
    check("rst_mid_inv_rdy", 256'(bus.minv_mdiv_rdy), 256'd0);
    bus.out_en   = 1'b1;
    bus.out_addr = 2'd1;
    #1;
    check("rst_mid_dataout", 256'(bus.dataout), 256'd0);
    bus.out_en = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (300) tick();
    check("post_rst_mul_rdy", 256'(bus.mmul_rdy), 256'd0);
    check("post_rst_add_rdy", 256'(bus.madd_msub_rdy), 256'd0);
    read_result(2'd1, 256'd0, "post_rst_r1");
    read_result(2'd0, 256'd0, "post_rst_r0");

    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pfcop.md
PFCOP -- requirements
Module: pfcop

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port load_en, input, 1 bit: operand load strobe.
REQ-004 The block SHALL have port load_addr, input, 4 bits: operand select; 3=A, 4=B, 5=P, other codes write nothing.
REQ-005 The block SHALL have port datain, input, 16 bits: operand word, least-significant word first.
REQ-006 The block SHALL have ports madd_en and msub_en, inputs, 1 bit each: start modular add / modular subtract.
REQ-007 The block SHALL have port mmul_en, input, 1 bit: start modular multiply.
REQ-008 The block SHALL have port minv_mdiv, input, 1 bit: mode select, 0=inverse, 1=divide; sampled with minv_mdiv_en.
REQ-009 The block SHALL have port minv_mdiv_en, input, 1 bit: start inverse/divide.
REQ-010 The block SHALL have port out_en, input, 1 bit: result readout strobe.
REQ-011 The block SHALL have port out_addr, input, 2 bits: result select; 0=add/sub, 1=mul, 2=inv/div, 3=all-zero.
REQ-012 The block SHALL have port dataout, output, 16 bits: result word.
REQ-013 The block SHALL have ports madd_msub_rdy, mmul_rdy and minv_mdiv_rdy, outputs, 1 bit each: result-valid flags.

Function
REQ-014 Registers A, B, P SHALL be 256 bits, each loaded as 16 words of 16 bits.
REQ-015 Load word index SHALL be a 4-bit counter: while load_en=1, datain is written to word[index] of the selected register and index increments each cycle (wraps 15->0); the counter clears when load_en=0 or load_addr differs from its previous-cycle value, so a new register starts at word 0 with no idle cycle.
REQ-016 Operands SHALL satisfy A,B<P and P odd; behaviour outside this range is unspecified, except as stated in REQ-023.
REQ-017 Each unit SHALL copy A, B and P at start, so reloading registers during an operation does not affect it.
REQ-018 madd_en SHALL produce R0=(A+B) mod P using a 257-bit sum minus P when the sum is >=P; msub_en SHALL produce R0=(A-B) mod P, adding P on borrow.
REQ-019 Add/sub SHALL complete in 1 cycle: madd_msub_rdy is 0 in the start cycle and 1 from the next edge; if madd_en and msub_en are both 1, add wins.
REQ-020 mmul_en SHALL compute R1=A*B mod P by MSB-first interleaved shift-add over 256 iterations, one per cycle; each iteration doubles R mod P, then adds B mod P if the A bit is 1.
REQ-021 mmul_rdy SHALL go 0 at start and 1 after the 256th iteration, i.e. at most 258 cycles after start.
REQ-022 minv_mdiv_en SHALL compute R2 by the binary extended Euclidean algorithm: u=denominator, v=P, x1=numerator, x2=0, halving mod P, until u==1 or v==1.
REQ-023 For inverse (minv_mdiv=0), R2=A^-1 mod P (denominator A, numerator 1); for divide, R2=A*B^-1 mod P (denominator B, numerator A). A zero denominator SHALL end the operation immediately with R2=0.
REQ-024 minv_mdiv_rdy SHALL go 0 at start and 1 at completion; latency is data-dependent and at most 1100 cycles for 256-bit P.
REQ-025 A start pulse SHALL be ignored while its own unit is busy; units are independent and may run concurrently.
REQ-026 Each rdy flag SHALL stay 1 until the next accepted start of its unit or reset.
REQ-027 Readout SHALL use a 4-bit word counter that is 0 while out_en=0; while out_en=1, dataout = selected result word[counter] (combinational), and the counter increments each cycle, wrapping after 16 words.
REQ-028 dataout SHALL be 0 when out_en=0 or out_addr=3; reading a result whose rdy is 0 returns its current register contents.

Reset
REQ-029 rst=0 SHALL asynchronously clear A, B, P, R0, R1, R2, all counters and busy state, all rdy outputs and dataout to 0.
REQ-030 Reset asserted mid-operation SHALL abort it; after release no rdy asserts until a new start.

Verification
REQ-031 P=23, A=5, B=20, madd_en pulse -> next cycle madd_msub_rdy=1; out_addr=0 readout word0=0x0002, words 1-15=0.
REQ-032 Same operands, msub_en -> R0=8; madd_en and msub_en pulsed together -> R0=2.
REQ-033 Same operands, mmul_en -> mmul_rdy within 258 cycles, R1=8; P-192 (FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF) with A=5F990446..334C74C7 and B=59BDCEE3..2139F0A0 -> R1 equals (A*B)%P from the software model.
REQ-034 Same operands, minv_mdiv=0 -> R2=14; minv_mdiv=1 -> R2=6; A=0 with inverse -> R2=0 and rdy=1.
REQ-035 Load with load_en held for 48 cycles and load_addr switching 3->4->5 every 16 cycles -> A, B, P exactly match the streamed words; out_en held 16 cycles -> 16 words output LSW first, then dataout=0 after out_en drops.
REQ-036 rst asserted while mmul is busy -> all outputs 0 immediately and mmul_rdy remains 0 after release until the next start.
